// File: rtl/mod_float_to_fixed_if.sv
// Handshake/data bundle between a float producer and mod_float_to_fixed.
// The requester drives in_A/in_En; the converter drives the result and status.
interface mod_float_to_fixed_if #(
   parameter int OUT_W = 16
);
   logic [15:0]      in_A;
   logic             in_En;
   logic [OUT_W-1:0] out_Out;
   logic             out_Ready;
   logic             out_Busy;

   modport master (output in_A, in_En, input out_Out, out_Ready, out_Busy);
   modport slave  (input in_A, in_En, output out_Out, out_Ready, out_Busy);
endinterface

// File: rtl/mod_float_to_fixed.sv
// Iterative 16-bit float to signed Q-format converter: one shift per cycle,
// saturating on left-shift overflow, truncating toward zero on right shifts.
module mod_float_to_fixed #(
   parameter int BIAS      = 15,
   parameter int FRAC_BITS = 8,
   parameter int OUT_W     = 16
) (
   input logic                 clk,
   input logic                 rst,
   mod_float_to_fixed_if.slave bus
);
   localparam int CW   = $clog2(OUT_W + 2);
   localparam int NMAX = OUT_W + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, PACK} state_t;

   state_t           state, stateNext;
   logic             sign;
   logic             dirLeft;
   logic [CW-1:0]    cnt;
   logic [OUT_W-1:0] mag;
   logic             ovf;
   logic [OUT_W-1:0] outOut;
   logic             outReady;

   logic             accept;
   logic             isZero;
   int               sCalc;
   int               sAbs;
   int               nInt;
   logic [CW-1:0]    nCalc;
   logic [OUT_W-1:0] magInit;
   logic [OUT_W-1:0] packVal;

   localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

   // Decode of the incoming operand, only consumed on the accept edge.
   always_comb begin
      isZero  = (bus.in_A[14:0] == '0);
      sCalc   = int'(bus.in_A[14:10]) - BIAS - 10 + FRAC_BITS;
      sAbs    = (sCalc < 0) ? -sCalc : sCalc;
      nInt    = isZero ? 0 : ((sAbs > NMAX) ? NMAX : sAbs);
      nCalc   = CW'(nInt);
      magInit = isZero ? '0 : {{(OUT_W-11){1'b0}}, 1'b1, bus.in_A[9:0]};
   end

   always_comb begin
      if (ovf)
         packVal = sign ? SAT_NEG : SAT_POS;
      else
         packVal = sign ? -mag : mag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_En) begin
               accept    = 1'b1;
               stateNext = (nCalc != '0) ? SHIFT : PACK;
            end
         end
         SHIFT:   if (cnt == CW'(1)) stateNext = PACK;
         PACK:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sign     <= 1'b0;
         dirLeft  <= 1'b0;
         cnt      <= '0;
         mag      <= '0;
         ovf      <= 1'b0;
         outOut   <= '0;
         outReady <= 1'b0;
      end else begin
         outReady <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  sign    <= bus.in_A[15];
                  dirLeft <= (sCalc > 0);
                  cnt     <= nCalc;
                  mag     <= magInit;
                  ovf     <= 1'b0;
               end
            end
            SHIFT: begin
               cnt <= cnt - 1'b1;
               if (dirLeft) begin
                  // A one leaving bit OUT_W-2 would land in the sign position.
                  if (mag[OUT_W-2]) ovf <= 1'b1;
                  mag <= mag << 1;
               end else begin
                  mag <= mag >> 1;
               end
            end
            PACK: begin
               outOut   <= packVal;
               outReady <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_Out   = outOut;
   assign bus.out_Ready = outReady;
   assign bus.out_Busy  = (state != IDLE);
endmodule

// File: tb/tb_mod_float_to_fixed.sv
// Directed and randomized bench for mod_float_to_fixed in its default Q7.8 setup.
module tb_mod_float_to_fixed;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mod_float_to_fixed_if #(.OUT_W(16)) bus ();

   mod_float_to_fixed #(.BIAS(15), .FRAC_BITS(8), .OUT_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Launch one conversion from idle; returns result, edges from accept to ready, and pulse width check.
   task automatic runOne(input logic [15:0] a, output logic [15:0] res, output int lat, output bit single);
      @(negedge clk);
      bus.in_A  = a;
      bus.in_En = 1'b1;
      @(posedge clk);
      #1;
      bus.in_En = 1'b0;
      bus.in_A  = ~a;
      lat    = -1;
      res    = 16'hxxxx;
      single = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_Ready) begin
            lat = i;
            res = bus.out_Out;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk);
         #1;
         single = !bus.out_Ready;
      end
   endtask

   // Independent arithmetic reference: scale 1.mant by 2^(exp-17) directly.
   task automatic refConv(input logic [15:0] a, output logic [15:0] val, output int n);
      int     e;
      int     s;
      longint v;
      e = int'(a[14:10]);
      if (a[14:0] == 15'd0) begin
         val = 16'h0000;
         n   = 0;
      end else begin
         s = e - 17;
         v = 64'd1024 + longint'(a[9:0]);
         if (s >= 0) begin
            n = (s > 17) ? 17 : s;
            v = v << s;
            if (v > 32767) v = 32767;
         end else begin
            n = (-s > 17) ? 17 : -s;
            v = (-s >= 40) ? 0 : (v >> (-s));
         end
         if (a[15]) v = -v;
         val = v[15:0];
      end
   endtask

   task automatic test_reset();
      bus.in_A  = 16'h0000;
      bus.in_En = 1'b0;
      rst       = 1'b0;
      #12;
      total++;
      if (bus.out_Out !== 16'h0000 || bus.out_Ready !== 1'b0 || bus.out_Busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: out=%h ready=%b busy=%b required out=0000 ready=0 busy=0",
                  bus.out_Out, bus.out_Ready, bus.out_Busy);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [15:0] res;
      int          lat;
      bit          single;
      runOne(16'h3C00, res, lat, single);
      total++;
      if (res !== 16'h0100 || lat !== 3 || !single) begin
         bad++;
         $display("FAIL basic_1p0: out=%h lat=%0d single=%0b required out=0100 lat=3 single=1", res, lat, single);
      end
      runOne(16'hC100, res, lat, single);
      total++;
      if (res !== 16'hFD80 || lat !== 2 || !single) begin
         bad++;
         $display("FAIL basic_m2p5: out=%h lat=%0d single=%0b required out=fd80 lat=2 single=1", res, lat, single);
      end
   endtask

   task automatic test_boundary();
      logic [15:0] vecA [4] = '{16'h47FF, 16'h0000, 16'h8000, 16'h0001};
      logic [15:0] vecR [4] = '{16'h07FF, 16'h0000, 16'h0000, 16'h0000};
      int          vecL [4] = '{1, 1, 1, 18};
      logic [15:0] res;
      int          lat;
      bit          single;
      for (int i = 0; i < 4; i++) begin
         runOne(vecA[i], res, lat, single);
         total++;
         if (res !== vecR[i] || lat !== vecL[i] || !single) begin
            bad++;
            $display("FAIL boundary_%h: out=%h lat=%0d single=%0b required out=%h lat=%0d single=1",
                     vecA[i], res, lat, single, vecR[i], vecL[i]);
         end
      end
   endtask

   task automatic test_saturation();
      // 0x5BFF is 2047*2^5 = 65504, which does not fit and therefore saturates.
      logic [15:0] vecA [4] = '{16'h7800, 16'hF800, 16'h5BFF, 16'h57FF};
      logic [15:0] vecR [4] = '{16'h7FFF, 16'h8001, 16'h7FFF, 16'h7FF0};
      int          vecL [4] = '{14, 14, 6, 5};
      logic [15:0] res;
      int          lat;
      bit          single;
      for (int i = 0; i < 4; i++) begin
         runOne(vecA[i], res, lat, single);
         total++;
         if (res !== vecR[i] || lat !== vecL[i] || !single) begin
            bad++;
            $display("FAIL sat_%h: out=%h lat=%0d single=%0b required out=%h lat=%0d single=1",
                     vecA[i], res, lat, single, vecR[i], vecL[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      int pulses;
      @(negedge clk);
      bus.in_A  = 16'h7800;
      bus.in_En = 1'b1;
      @(posedge clk);
      #1;
      bus.in_En = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      total++;
      if (bus.out_Out !== 16'h0000 || bus.out_Ready !== 1'b0 || bus.out_Busy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: out=%h ready=%b busy=%b required out=0000 ready=0 busy=0",
                  bus.out_Out, bus.out_Ready, bus.out_Busy);
      end
      @(negedge clk);
      rst    = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.out_Ready) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL reset_abandon: ready_pulses=%0d required 0", pulses);
      end
   endtask

   task automatic test_handshake();
      int          lat;
      int          extra;
      logic [15:0] res;
      @(negedge clk);
      bus.in_A  = 16'h4000;
      bus.in_En = 1'b1;
      @(posedge clk);
      #1;
      // Keep requesting across both busy cycles with a different operand.
      bus.in_A = 16'h7800;
      lat      = -1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_Ready) begin
            lat = i;
            res = bus.out_Out;
            break;
         end
      end
      bus.in_En = 1'b0;
      total++;
      if (res !== 16'h0200 || lat !== 2) begin
         bad++;
         $display("FAIL busy_ignore: out=%h lat=%0d required out=0200 lat=2", res, lat);
      end
      extra = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (bus.out_Ready || bus.out_Busy) extra++;
      end
      total++;
      if (extra !== 0 || bus.out_Out !== 16'h0200) begin
         bad++;
         $display("FAIL no_queue: extra_cycles=%0d out=%h required 0 and 0200", extra, bus.out_Out);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [4] = '{16'h3C00, 16'hC100, 16'h47FF, 16'h4000};
      logic [15:0] exps [4] = '{16'h0100, 16'hFD80, 16'h07FF, 16'h0200};
      int          gaps [4] = '{3, 3, 2, 3};
      int          gap;
      @(negedge clk);
      bus.in_A  = vals[0];
      bus.in_En = 1'b1;
      @(posedge clk);
      #1;
      bus.in_A = 16'hDEAD;
      for (int k = 0; k < 4; k++) begin
         gap = -1;
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_Ready) begin
               gap = i;
               break;
            end
         end
         total++;
         if (bus.out_Out !== exps[k] || gap !== gaps[k] || bus.out_Busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_%0d: out=%h gap=%0d busy=%b required out=%h gap=%0d busy=0",
                     k, bus.out_Out, gap, bus.out_Busy, exps[k], gaps[k]);
         end
         if (k < 3) bus.in_A = vals[k+1];
         else       bus.in_En = 1'b0;
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.out_Ready !== 1'b0 || bus.out_Busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: ready=%b busy=%b required 0 0", bus.out_Ready, bus.out_Busy);
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] res;
      logic [15:0] expVal;
      int          n;
      int          lat;
      bit          single;
      logic [31:0] r;
      for (int i = 0; i < 1000; i++) begin
         r = $urandom();
         a = r[15:0];
         refConv(a, expVal, n);
         runOne(a, res, lat, single);
         total++;
         if (res !== expVal || lat !== n + 1 || !single) begin
            bad++;
            $display("FAIL random_%h: out=%h lat=%0d single=%0b required out=%h lat=%0d single=1",
                     a, res, lat, single, expVal, n + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_saturation();
      test_async_reset();
      test_handshake();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
